// File: rtl/cordic_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : cordic_seq_if
// Brief    : Host-side handshake and operand/result bundle for cordic_seq.
//            CORDIC_VECTORING_EN adds the mode_i select.
// Revision : 1.0
// ============================================================================
interface cordic_seq_if #(
    parameter int WIDTH = 16
);
    logic             start_i;
    logic [WIDTH-1:0] x_i;
    logic [WIDTH-1:0] y_i;
    logic [WIDTH-1:0] z_i;
`ifdef CORDIC_VECTORING_EN
    logic             mode_i;
`endif
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] x_o;
    logic [WIDTH-1:0] y_o;
    logic [WIDTH-1:0] z_o;

`ifdef CORDIC_VECTORING_EN
    modport master (
        output start_i, x_i, y_i, z_i, mode_i,
        input  busy_o, done_o, x_o, y_o, z_o
    );
    modport slave (
        input  start_i, x_i, y_i, z_i, mode_i,
        output busy_o, done_o, x_o, y_o, z_o
    );
`else
    modport master (
        output start_i, x_i, y_i, z_i,
        input  busy_o, done_o, x_o, y_o, z_o
    );
    modport slave (
        input  start_i, x_i, y_i, z_i,
        output busy_o, done_o, x_o, y_o, z_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/cordic_seq.sv
`default_nettype none
// ============================================================================
// Module   : cordic_seq (with helper sum_sel)
// Brief    : Iterative CORDIC sequencer, one micro-rotation per clock.
//            CORDIC_VECTORING_EN enables the vectoring mode via mode_i.
// Revision : 1.0
// ============================================================================
module sum_sel #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_add,
    output logic [WIDTH-1:0] o_sum
);
    assign o_sum = i_add ? (i_a + i_b) : (i_a - i_b);
endmodule

module cordic_seq #(
    parameter int WIDTH      = 16,
    parameter int ITERATIONS = 14
) (
    input  logic        clk_i,
    input  logic        rst_i,
    cordic_seq_if.slave bus
);
    localparam int c_cnt_w     = $clog2(ITERATIONS + 1);
    localparam int c_rom_depth = 1 << c_cnt_w;

    if (ITERATIONS < 1 || ITERATIONS > WIDTH - 1) begin : g_bad_iterations
        $error("cordic_seq: ITERATIONS must lie in 1..WIDTH-1");
    end

    // atan(2^-i) in radians; beyond i=14 the cubic Taylor term is exact to double precision.
    function automatic real atan_pow2(input int idx);
        real t;
        t = 1.0;
        for (int k = 0; k < idx; k++) t = t / 2.0;
        case (idx)
            0:       atan_pow2 = 0.7853981633974483;
            1:       atan_pow2 = 0.4636476090008061;
            2:       atan_pow2 = 0.24497866312686414;
            3:       atan_pow2 = 0.12435499454676144;
            4:       atan_pow2 = 0.06241880999595735;
            5:       atan_pow2 = 0.031239833430268277;
            6:       atan_pow2 = 0.015623728620476831;
            7:       atan_pow2 = 0.007812341060101111;
            8:       atan_pow2 = 0.0039062301319669718;
            9:       atan_pow2 = 0.0019531225164788188;
            10:      atan_pow2 = 0.0009765621895593195;
            11:      atan_pow2 = 0.0004882812111948983;
            12:      atan_pow2 = 0.00024414062014936177;
            13:      atan_pow2 = 0.00012207031189367021;
            14:      atan_pow2 = 0.00006103515617420877;
            default: atan_pow2 = t - (t * t * t) / 3.0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] atan_fixed(input int idx);
        real scale;
        scale = 1.0;
        for (int k = 0; k < WIDTH - 3; k++) scale = scale * 2.0;
        atan_fixed = WIDTH'($rtoi(atan_pow2(idx) * scale + 0.5));
    endfunction

    logic [WIDTH-1:0] w_atan_rom [c_rom_depth];

    for (genvar g = 0; g < c_rom_depth; g++) begin : g_atan_rom
        if (g < ITERATIONS) begin : g_used
            assign w_atan_rom[g] = atan_fixed(g);
        end else begin : g_unused
            assign w_atan_rom[g] = '0;
        end
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_iter;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_y;
    logic [WIDTH-1:0]     r_z;
    logic [WIDTH-1:0]     r_x_o;
    logic [WIDTH-1:0]     r_y_o;
    logic [WIDTH-1:0]     r_z_o;
    logic                 w_load;
    logic                 w_last;
    logic                 w_dir;
    logic [WIDTH-1:0]     w_x_shift;
    logic [WIDTH-1:0]     w_y_shift;
    logic [WIDTH-1:0]     w_x_next;
    logic [WIDTH-1:0]     w_y_next;
    logic [WIDTH-1:0]     w_z_next;

`ifdef CORDIC_VECTORING_EN
    logic r_mode;
    // Vectoring steers y toward zero; rotation steers z toward zero.
    assign w_dir = r_mode ? ~r_y[WIDTH-1] : r_z[WIDTH-1];
`else
    assign w_dir = r_z[WIDTH-1];
`endif

    assign w_last    = (r_iter == c_cnt_w'(ITERATIONS - 1));
    assign w_x_shift = $unsigned($signed(r_x) >>> r_iter);
    assign w_y_shift = $unsigned($signed(r_y) >>> r_iter);

    sum_sel #(.WIDTH(WIDTH)) u_sum_x (
        .i_a   (r_x),
        .i_b   (w_y_shift),
        .i_add (w_dir),
        .o_sum (w_x_next)
    );

    sum_sel #(.WIDTH(WIDTH)) u_sum_y (
        .i_a   (r_y),
        .i_b   (w_x_shift),
        .i_add (~w_dir),
        .o_sum (w_y_next)
    );

    sum_sel #(.WIDTH(WIDTH)) u_sum_z (
        .i_a   (r_z),
        .i_b   (w_atan_rom[r_iter]),
        .i_add (w_dir),
        .o_sum (w_z_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.start_i) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_iter  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_x_o   <= '0;
            r_y_o   <= '0;
            r_z_o   <= '0;
`ifdef CORDIC_VECTORING_EN
            r_mode  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_x    <= bus.x_i;
                r_y    <= bus.y_i;
                r_z    <= bus.z_i;
                r_iter <= '0;
`ifdef CORDIC_VECTORING_EN
                r_mode <= bus.mode_i;
`endif
            end else if (r_state == ST_RUN) begin
                r_x <= w_x_next;
                r_y <= w_y_next;
                r_z <= w_z_next;
                if (w_last) begin
                    r_iter <= '0;
                    r_x_o  <= w_x_next;
                    r_y_o  <= w_y_next;
                    r_z_o  <= w_z_next;
                end else begin
                    r_iter <= r_iter + c_cnt_w'(1);
                end
            end
        end
    end

    assign bus.busy_o = (r_state == ST_RUN);
    assign bus.done_o = (r_state == ST_DONE);
    assign bus.x_o    = r_x_o;
    assign bus.y_o    = r_y_o;
    assign bus.z_o    = r_z_o;
endmodule
`default_nettype wire

// File: tb/tb_cordic_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_seq
// Brief    : Randomized self-checking bench for cordic_seq against a
//            floating-point-derived CORDIC reference (CORDIC_VECTORING_EN aware).
// Revision : 1.0
// ============================================================================
module tb_cordic_seq;
    localparam int c_width = 16;
    localparam int c_iter  = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cordic_seq_if #(.WIDTH(c_width)) bus ();

    cordic_seq #(.WIDTH(c_width), .ITERATIONS(c_iter)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int atan_tbl [c_iter];

    task automatic check(input string tag, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: textbook CORDIC on 16-bit wrapping integers.
    function automatic void cordic_model(input int x0, input int y0, input int z0, input bit vec,
                                         output int xr, output int yr, output int zr);
        logic signed [15:0] x, y, z, xn, yn, a;
        bit d;
        x = x0[15:0];
        y = y0[15:0];
        z = z0[15:0];
        for (int i = 0; i < c_iter; i++) begin
            a = atan_tbl[i][15:0];
            d = vec ? (y >= 0) : (z < 0);
            if (d) begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                z  = z + a;
            end else begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                z  = z - a;
            end
            x = xn;
            y = yn;
        end
        xr = x;
        yr = y;
        zr = z;
    endfunction

    task automatic drive_operands(input int x, input int y, input int z, input bit vec);
        bus.x_i = x[15:0];
        bus.y_i = y[15:0];
        bus.z_i = z[15:0];
`ifdef CORDIC_VECTORING_EN
        bus.mode_i = vec;
`else
        if (vec) $display("note: vectoring requested in rotation-only build");
`endif
    endtask

    task automatic check_outputs(input string tag, input int xe, input int ye, input int ze);
        check({tag, "_x"}, longint'($signed(bus.x_o)), xe);
        check({tag, "_y"}, longint'($signed(bus.y_o)), ye);
        check({tag, "_z"}, longint'($signed(bus.z_o)), ze);
    endtask

    // One request from IDLE; optional disturbance of inputs and a stray start during RUN.
    task automatic do_op(input string tag, input int x, input int y, input int z,
                         input bit vec, input bit disturb);
        int cycles, busy_miss, xe, ye, ze;
        cordic_model(x, y, z, vec, xe, ye, ze);
        drive_operands(x, y, z, vec);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        cycles    = 0;
        busy_miss = 0;
        while (!bus.done_o && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (!bus.done_o && !bus.busy_o) busy_miss++;
            if (disturb) begin
                bus.x_i     = 16'($urandom);
                bus.y_i     = 16'($urandom);
                bus.z_i     = 16'($urandom);
                bus.start_i = (cycles == 2);
            end
        end
        bus.start_i = 1'b0;
        check({tag, "_latency"}, cycles, c_iter);
        check({tag, "_busy_run"}, busy_miss, 0);
        check({tag, "_busy_done"}, bus.busy_o, 0);
        check_outputs(tag, xe, ye, ze);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, bus.done_o, 0);
        if (disturb) begin
            repeat (10) begin
                bus.x_i = 16'($urandom);
                @(posedge clk); #1;
            end
            check_outputs({tag, "_hold"}, xe, ye, ze);
            check({tag, "_idle"}, bus.busy_o, 0);
        end
    endtask

    initial begin
        int cyc, last, ndone, xe, ye, ze, dones;
        for (int i = 0; i < c_iter; i++)
            atan_tbl[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 8192.0 + 0.5);

        rst = 1'b1;
        bus.start_i = 1'b0;
        drive_operands(0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check_outputs("rst", 0, 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("rot45", 4975, 0, 6434, 1'b0, 1'b0);
        check($sformatf("rot45_x_tol(%0d)", $signed(bus.x_o)), iabs(int'($signed(bus.x_o)) - 5793) <= 4, 1);
        check($sformatf("rot45_y_tol(%0d)", $signed(bus.y_o)), iabs(int'($signed(bus.y_o)) - 5793) <= 4, 1);
        check($sformatf("rot45_z_tol(%0d)", $signed(bus.z_o)), iabs(int'($signed(bus.z_o))) <= 4, 1);

        do_op("rotm90", 4975, 0, -12868, 1'b0, 1'b0);
        check($sformatf("rotm90_x_tol(%0d)", $signed(bus.x_o)), iabs(int'($signed(bus.x_o))) <= 4, 1);
        check($sformatf("rotm90_y_tol(%0d)", $signed(bus.y_o)), iabs(int'($signed(bus.y_o)) + 8192) <= 4, 1);

        do_op("disturb", 3000, -1500, 5000, 1'b0, 1'b1);

        for (int n = 0; n < 12; n++) begin
            do_op($sformatf("rand%0d", n),
                  int'($urandom_range(8000)) - 4000,
                  int'($urandom_range(8000)) - 4000,
                  int'($urandom_range(25736)) - 12868,
                  1'b0, (n % 4) == 3);
        end

        // Start held high: back-to-back completions.
        cordic_model(2500, 1200, -3000, 1'b0, xe, ye, ze);
        drive_operands(2500, 1200, -3000, 1'b0);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        cyc = 0; last = 0; ndone = 0;
        while (ndone < 3 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done_o) begin
                ndone++;
                check($sformatf("b2b_interval%0d", ndone), cyc - last, (ndone == 1) ? c_iter : c_iter + 1);
                check_outputs($sformatf("b2b%0d", ndone), xe, ye, ze);
                last = cyc;
            end
        end
        check("b2b_count", ndone, 3);
        bus.start_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Reset at RUN cycle 5 aborts the request.
        drive_operands(4000, 500, 2000, 1'b0);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", bus.busy_o, 0);
        check("abort_done", bus.done_o, 0);
        check_outputs("abort", 0, 0, 0);
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done_o || bus.busy_o) dones++;
        end
        check("abort_quiet", dones, 0);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check("rst_start_busy", bus.busy_o, 0);

`ifdef CORDIC_VECTORING_EN
        do_op("vec", 8192, 8192, 0, 1'b1, 1'b0);
        check($sformatf("vec_y_tol(%0d)", $signed(bus.y_o)), iabs(int'($signed(bus.y_o))) <= 4, 1);
        check($sformatf("vec_z_tol(%0d)", $signed(bus.z_o)), iabs(int'($signed(bus.z_o)) - 6434) <= 4, 1);
        check($sformatf("vec_x_tol(%0d)", $signed(bus.x_o)), iabs(int'($signed(bus.x_o)) - 19079) <= 8, 1);
        do_op("vec_rand", 6000, -3000, 1000, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cordic_seq.md
# cordic_seq

Iterative CORDIC sequencer. It owns the x/y/z working registers and the iteration counter, and drives three `sum_sel` add/subtract instances once per clock with the direction bit and shifted operands for the current iteration. A start/busy/done handshake lets a host issue one rotation per request. It is the control layer between the host and the add/subtract datapath.

## Interface
- `Width`, 16: datapath width, signed two's complement, format Q3.(Width-3) for x, y and z (z in radians).
- `Iterations`, 14: number of micro-rotations. Legal range 1..Width-1; elaboration error otherwise.
- `clk_i` in 1: clock. One clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: request. Sampled on the rising edge; accepted only in IDLE or DONE.
- `x_i` in Width: initial x. Caller pre-scales by 1/K (about 0.60725); no gain compensation inside.
- `y_i` in Width: initial y.
- `z_i` in Width: initial angle. The convergence range is |z| ≤ π/2.
- `busy_o` out 1: high in RUN.
- `done_o` out 1: one-cycle pulse in DONE.
- `x_o`, `y_o`, `z_o` out Width each: registered results, held until the next accepted start.

## Operation
- **States:** IDLE, RUN, DONE. State encoding is free.
- **IDLE:**
  - `start_i` = 1: load x/y/z from the inputs, clear iteration index i, go to RUN.
  - Otherwise stay in IDLE.
- **RUN:** one micro-rotation per cycle, using direction d and `sum_sel` semantics (d = 1 → add, d = 0 → subtract):
  - d = z[Width-1] in rotation mode (1 = z negative).
  - x' = sum_sel(x, y>>>i, d)
  - y' = sum_sel(y, x>>>i, ~d)
  - z' = sum_sel(z, atan_i, d)
  - `>>>` is an arithmetic shift. All sums wrap at Width bits; no saturation.
- **Arctangent constants:** atan_i = round(atan(2^-i)·2^(Width-3)). These are elaboration-time constants (ROM), indexed by i.
- **End of RUN:** when i = Iterations-1 the update is applied, the results are copied to `x_o`/`y_o`/`z_o`, and the state goes to DONE. Otherwise i increments.
- **DONE:**
  - Lasts exactly one cycle.
  - `start_i` = 1 in DONE: load and go directly to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- **`start_i` in RUN:** ignored. It is neither queued nor flagged.
- **Iteration counter width:** $clog2(Iterations+1).

## Timing
- **Reset values:** state IDLE, i = 0, `busy_o` = 0, `done_o` = 0, `x_o`/`y_o`/`z_o` = 0, working registers 0.
- **Start:** with `start_i` sampled at edge k, `busy_o` is high from edge k+1 to edge k+Iterations.
- **Done:** `done_o` and the new outputs appear at edge k+Iterations.
  - The done pulse is Iterations cycles after acceptance.
  - Back-to-back throughput is one result per Iterations+1 cycles.
- **Output hold:** `x_o`/`y_o`/`z_o` change only at the DONE transition and hold their values otherwise, including through IDLE.
- **Reset mid-RUN:** abort. Next cycle is IDLE with all outputs 0. No `done_o` pulse.
- **Reset and start in the same cycle:** reset wins and the start is dropped.
- **Input sampling:** `x_i`/`y_i`/`z_i` are sampled only on the accepting edge. Changing them during RUN has no effect.

## Configuration
- **Macro:** `CORDIC_VECTORING_EN`.
- **Defined:** adds input port `mode_i` (1 bit), sampled with `start_i`.
  - `mode_i` = 0: rotation mode, as above.
  - `mode_i` = 1: vectoring mode, d = ~y[Width-1]. Drives y toward 0: `x_o` = K·√(x²+y²), `z_o` = z + atan(y/x).
  - Vectoring requires x_i > 0.
- **Undefined:** there is no `mode_i` port and the block is rotation-only.
- **Unaffected:** the timing is identical in both builds.

## Test plan
1. **Reset mid-RUN:** start, then assert `rst_i` at RUN cycle 5 → next cycle IDLE, `busy_o` = 0, outputs 0, no `done_o` for that request.
2. **Rotation by π/4 (Width = 16):** x = 4975, y = 0, z = 6434 (π/4), start → `done_o` at edge +14; `x_o` ≈ `y_o` ≈ 5793 ±4, |`z_o`| ≤ 4.
3. **Negative angle:** x = 4975, y = 0, z = −12868 (−π/2) → `x_o` ≈ 0 ±4, `y_o` ≈ −8192 ±4, `done_o` a single one-cycle pulse.
4. **Start handling:**
   - `start_i` held high continuously → completions every 15 cycles.
   - A `start_i` pulse during RUN cycle 3 → ignored; the output corresponds to the first operands only.
5. **Input and output hold:** change `x_i`/`y_i`/`z_i` during RUN → results unchanged; outputs stable 10 cycles after DONE.
6. **Vectoring (`CORDIC_VECTORING_EN` defined):** `mode_i` = 1, x = 8192, y = 8192, z = 0 → `y_o` ≈ 0 ±4, `z_o` ≈ 6434 ±4, `x_o` ≈ 19079 ±8 (K·√2·8192).
